display_timings_272p: RTL and testbench

//  Display timing generator for the 480x272 LCD pipeline, clocked by the 18 MHz pixel clock.

---
 rtl/display_timings_272p_if.sv | 17 +
 rtl/display_timings_272p.sv | 118 +++++++++++
 tb/tb_display_timings_272p.sv | 137 +++++++++++++
 3 files changed

// File: rtl/display_timings_272p_if.sv
// Timing bundle from the 272p display timing generator to the drawing
// logic and the panel pins. The generator drives it (master), consumers
// only observe it (slave).
interface display_timings_272p_if #(
  parameter int CORDW = 10
);
  logic [CORDW-1:0] sx;     // horizontal position of the current pixel
  logic [CORDW-1:0] sy;     // vertical position of the current pixel
  logic             hsync;  // horizontal sync, polarity set by H_POL
  logic             vsync;  // vertical sync, polarity set by V_POL
  logic             de;     // data enable, high in the active area
  logic             frame;  // one-cycle strobe at (0,0)
  logic             line;   // one-cycle strobe at sx==0

  modport master (output sx, sy, hsync, vsync, de, frame, line);
  modport slave  (input  sx, sy, hsync, vsync, de, frame, line);
endinterface

// File: rtl/display_timings_272p.sv
// Display timing generator for the 480x272 LCD, running on the pixel clock.
// Every output is a flop. The next position is computed combinationally and
// all flags are derived from that next position, so everything presented in
// one cycle describes the same pixel.
module display_timings_272p #(
  parameter int   CORDW = 10,
  parameter int   H_RES = 480,
  parameter int   H_FP  = 32,
  parameter int   H_SW  = 48,
  parameter int   H_BP  = 40,
  parameter int   V_RES = 272,
  parameter int   V_FP  = 100,
  parameter int   V_SW  = 10,
  parameter int   V_BP  = 120,
  parameter logic H_POL = 1'b0,
  parameter logic V_POL = 1'b0
) (
  input  logic                          clk_pix,
  input  logic                          rst_pix,
  display_timings_272p_if.master        tim
);

  localparam int H_TOTAL = H_RES + H_FP + H_SW + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SW + V_BP;

  // Elaboration guards: the counters must be able to hold the last position,
  // and a zero-width porch or sync would collapse the timing regions.
  if (H_TOTAL > 2**CORDW) begin : g_err_htotal
    $error("display_timings_272p: H_TOTAL does not fit in CORDW bits");
  end
  if (V_TOTAL > 2**CORDW) begin : g_err_vtotal
    $error("display_timings_272p: V_TOTAL does not fit in CORDW bits");
  end
  if (H_FP == 0 || H_SW == 0 || H_BP == 0) begin : g_err_hzero
    $error("display_timings_272p: horizontal porch or sync width is zero");
  end
  if (V_FP == 0 || V_SW == 0 || V_BP == 0) begin : g_err_vzero
    $error("display_timings_272p: vertical porch or sync width is zero");
  end

  // Region boundaries, all unsigned at CORDW bits.
  localparam logic [CORDW-1:0] HA_END = CORDW'(H_RES);              // first blank pixel
  localparam logic [CORDW-1:0] HS_STA = CORDW'(H_RES + H_FP);       // first hsync pixel
  localparam logic [CORDW-1:0] HS_END = CORDW'(H_RES + H_FP + H_SW);// first pixel after hsync
  localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] VA_END = CORDW'(V_RES);
  localparam logic [CORDW-1:0] VS_STA = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] VS_END = CORDW'(V_RES + V_FP + V_SW);
  localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] ONE    = CORDW'(1);

  logic [CORDW-1:0] r_sx, r_sy;
  logic             r_hsync, r_vsync, r_de, r_frame, r_line;
  // Set after the first counting edge; until then the next position is (0,0)
  // so that release from reset always presents (0,0) with frame=1.
  logic             r_run;

  logic [CORDW-1:0] w_nx, w_ny;
  logic             w_hs_act, w_vs_act, w_de, w_frame, w_line;

  // Next position: hold at the origin for the first edge, then advance with
  // horizontal and vertical wrap.
  always_comb begin
    w_nx = '0;
    w_ny = '0;
    if (r_run) begin
      if (r_sx == H_LAST) begin
        w_nx = '0;
        w_ny = (r_sy == V_LAST) ? '0 : r_sy + ONE;
      end else begin
        w_nx = r_sx + ONE;
        w_ny = r_sy;
      end
    end
  end

  // Flags for the next position. vsync depends on the line only, so it can
  // only change when the line changes, i.e. on the edge where sx becomes 0.
  always_comb begin
    w_de     = (w_nx < HA_END) && (w_ny < VA_END);
    w_hs_act = (w_nx >= HS_STA) && (w_nx < HS_END);
    w_vs_act = (w_ny >= VS_STA) && (w_ny < VS_END);
    w_line   = (w_nx == '0);
    w_frame  = (w_nx == '0) && (w_ny == '0);
  end

  // Register position and flags together; reset parks everything inactive.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_run   <= 1'b0;
      r_sx    <= '0;
      r_sy    <= '0;
      r_de    <= 1'b0;
      r_frame <= 1'b0;
      r_line  <= 1'b0;
      r_hsync <= ~H_POL;
      r_vsync <= ~V_POL;
    end else begin
      r_run   <= 1'b1;
      r_sx    <= w_nx;
      r_sy    <= w_ny;
      r_de    <= w_de;
      r_frame <= w_frame;
      r_line  <= w_line;
      r_hsync <= w_hs_act ? H_POL : ~H_POL;
      r_vsync <= w_vs_act ? V_POL : ~V_POL;
    end
  end

  assign tim.sx    = r_sx;
  assign tim.sy    = r_sy;
  assign tim.hsync = r_hsync;
  assign tim.vsync = r_vsync;
  assign tim.de    = r_de;
  assign tim.frame = r_frame;
  assign tim.line  = r_line;

endmodule

// File: tb/tb_display_timings_272p.sv
// Bench for the 272p timing generator: a default-parameter instance and a
// tiny override instance, each with its own reset. Stimulus pushes the
// expected outputs of every edge into a per-instance queue; a monitor pops
// and compares one cycle later, 1 ns after the edge.
module tb_display_timings_272p;

  localparam int NCYC = 12000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b1;
  logic rst1 = 1'b1;

  display_timings_272p_if #(.CORDW(10)) if0 ();
  display_timings_272p_if #(.CORDW(4))  if1 ();

  display_timings_272p #(.CORDW(10)) u_dut0 (
    .clk_pix (clk),
    .rst_pix (rst0),
    .tim     (if0)
  );

  display_timings_272p #(
    .CORDW(4), .H_RES(8), .H_FP(1), .H_SW(2), .H_BP(1),
    .V_RES(4), .V_FP(1), .V_SW(1), .V_BP(1), .H_POL(1'b1), .V_POL(1'b1)
  ) u_dut1 (
    .clk_pix (clk),
    .rst_pix (rst1),
    .tim     (if1)
  );

  typedef struct {
    int sx; int sy;
    bit hs; bit vs; bit de; bit fr; bit ln;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   vectors = 0;
  int   errs    = 0;

  // Reference: n is the number of counting edges since the last reset
  // (0 means this edge is itself a reset edge). The pixel shown is simply
  // (n-1) modulo the frame size, laid out row-major.
  function automatic exp_t model(input int n,
                                 input int hres, input int hfp, input int hsw, input int hbp,
                                 input int vres, input int vfp, input int vsw, input int vbp,
                                 input bit hpol, input bit vpol);
    exp_t e;
    int ht, vt, p;
    ht = hres + hfp + hsw + hbp;
    vt = vres + vfp + vsw + vbp;
    if (n == 0) begin
      e.sx = 0; e.sy = 0; e.de = 0; e.fr = 0; e.ln = 0;
      e.hs = ~hpol; e.vs = ~vpol;
    end else begin
      p    = (n - 1) % (ht * vt);
      e.sx = p % ht;
      e.sy = p / ht;
      e.de = (e.sx < hres) && (e.sy < vres);
      e.hs = (e.sx >= hres + hfp && e.sx < hres + hfp + hsw) ? hpol : ~hpol;
      e.vs = (e.sy >= vres + vfp && e.sy < vres + vfp + vsw) ? vpol : ~vpol;
      e.ln = (e.sx == 0);
      e.fr = (e.sx == 0) && (e.sy == 0);
    end
    return e;
  endfunction

  task automatic check(input string nm, input exp_t e,
                       input int sx, input int sy, input bit hs, input bit vs,
                       input bit de, input bit fr, input bit ln);
    vectors++;
    if (sx != e.sx || sy != e.sy || hs != e.hs || vs != e.vs ||
        de != e.de || fr != e.fr || ln != e.ln) begin
      errs++;
      $display("FAIL %s @%0t: got sx=%0d sy=%0d hs=%0b vs=%0b de=%0b fr=%0b ln=%0b, want sx=%0d sy=%0d hs=%0b vs=%0b de=%0b fr=%0b ln=%0b",
               nm, $time, sx, sy, hs, vs, de, fr, ln,
               e.sx, e.sy, e.hs, e.vs, e.de, e.fr, e.ln);
    end
  endtask

  // Monitor: after every edge, compare whatever the stimulus predicted.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("dut0", e, int'(if0.sx), int'(if0.sy), if0.hsync, if0.vsync,
              if0.de, if0.frame, if0.line);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("dut1", e, int'(if1.sx), int'(if1.sy), if1.hsync, if1.vsync,
              if1.de, if1.frame, if1.line);
      end
    end
  end

  // Stimulus: reset decisions per cycle, expectation pushed for the next edge.
  initial begin
    int  n0 = 0;
    int  n1 = 0;
    bit  r0, r1;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      // dut0: 5-cycle reset, 12.5 lines of free run (covers active line,
      // hsync window and line strobes), a 1-cycle mid-line reset, then
      // sparse random resets.
      if (c < 5)                 r0 = 1'b1;
      else if (c == 7505)        r0 = 1'b1;
      else if (c < 9500)         r0 = 1'b0;
      else                       r0 = ($urandom_range(0, 999) < 2);
      // dut1: 5-cycle reset, three clean frames, then random 1..2 cycle resets.
      if (c < 5)                 r1 = 1'b1;
      else if (c < 5 + 3 * 84)   r1 = 1'b0;
      else                       r1 = ($urandom_range(0, 99) < 3);
      rst0 = r0;
      rst1 = r1;
      n0 = r0 ? 0 : n0 + 1;
      n1 = r1 ? 0 : n1 + 1;
      q0.push_back(model(n0, 480, 32, 48, 40, 272, 100, 10, 120, 1'b0, 1'b0));
      q1.push_back(model(n1, 8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b1));
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d/%0d expectations left, want 0/0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
